// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected on completion.
module ex_muldiv_unit #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  tag_out
);
    localparam int N  = DATA_W / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d, lo_q, lo_d, result_q, result_d;
    logic [DATA_W:0]     hi_q, hi_d;
    logic                neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
    logic [TAG_W-1:0]    tag_q, tag_d, tag_out_q, tag_out_d;

    logic                a_neg, b_neg, div_zero, ovf;
    logic [DATA_W-1:0]   a_mag, b_mag, l, q_s, r_s, fin;
    logic [DATA_W:0]     h, sum;
    logic [2*DATA_W-1:0] prod, prod_s;

    always_comb begin
        a_neg    = operand_a[DATA_W-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
        b_neg    = operand_b[DATA_W-1] & (op[2] ? ~op[0] : ~op[1]);
        a_mag    = a_neg ? -operand_a : operand_a;
        b_mag    = b_neg ? -operand_b : operand_b;
        div_zero = op[2] & (operand_b == '0);
        ovf      = op[2] & ~op[0] & (operand_a == {1'b1, {(DATA_W-1){1'b0}}}) & (&operand_b);
    end

    // hi holds the running product high half (multiply) or partial remainder (divide);
    // lo holds the multiplier being shifted out or the dividend/quotient.
    always_comb begin
        h   = hi_q;
        l   = lo_q;
        sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                h = {h[DATA_W-1:0], l[DATA_W-1]};
                l = {l[DATA_W-2:0], 1'b0};
                if (h >= {1'b0, opnd_q}) begin
                    h    = h - {1'b0, opnd_q};
                    l[0] = 1'b1;
                end
            end else begin
                sum = {1'b0, h[DATA_W-1:0]} + (l[0] ? {1'b0, opnd_q} : '0);
                l   = {sum[0], l[DATA_W-1:1]};
                h   = {1'b0, sum[DATA_W:1]};
            end
        end
        prod   = {h[DATA_W-1:0], l};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -l : l;
        r_s    = rneg_q ? -h[DATA_W-1:0] : h[DATA_W-1:0];
        fin    = op_q[2] ? (op_q[1] ? r_s : q_s)
                         : ((op_q[1:0] == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[2*DATA_W-1:DATA_W]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (start && !kill) begin
                op_d  = op;
                tag_d = tag_in;
                if (div_zero || ovf) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    tag_out_d = tag_in;
                    result_d  = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);
                end else begin
                    state_d = CALC;
                    cnt_d   = CW'(N);
                    opnd_d  = op[2] ? b_mag : a_mag;
                    hi_d    = '0;
                    lo_d    = op[2] ? a_mag : b_mag;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            CALC: if (kill) begin
                state_d = IDLE;
            end else begin
                hi_d  = h;
                lo_d  = l;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    result_d  = fin;
                    tag_out_d = tag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
            done_q    <= done_d;
        end
    end

    assign stall   = reset & (((state_q == IDLE) & start & ~kill) | (state_q == CALC));
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_out_q;
endmodule
